// File: rtl/dram_fifo_ctrl_if.sv
// Bus bundle for dram_fifo_ctrl: upstream CHDR input, FIFO input side,
// FIFO output tap (monitor only) and the settings-bus write port.
// The controller uses the master modport; its environment uses slave.
interface dram_fifo_ctrl_if;
   // upstream CHDR stream
   logic [63:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;
   // stream into the DRAM FIFO
   logic [63:0] f_tdata;
   logic        f_tlast;
   logic        f_tvalid;
   logic        f_tready;
   // FIFO output tap, observed only
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready;
   // settings bus write port
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;

   modport master (
      input  i_tdata, i_tlast, i_tvalid,
      output i_tready,
      output f_tdata, f_tlast, f_tvalid,
      input  f_tready,
      input  o_tlast, o_tvalid, o_tready,
      output set_stb, set_addr, set_data
   );

   modport slave (
      output i_tdata, i_tlast, i_tvalid,
      input  i_tready,
      input  f_tdata, f_tlast, f_tvalid,
      output f_tready,
      output o_tlast, o_tvalid, o_tready,
      input  set_stb, set_addr, set_data
   );
endinterface

// File: rtl/dram_fifo_ctrl.sv
// dram_fifo_ctrl: bring-up and flow controller in front of a DRAM FIFO.
// Waits for DRAM calibration, clears the FIFO over the settings bus,
// gates upstream CHDR traffic on packet boundaries and tracks how many
// packets are resident in the FIFO.
// Optional statistics (packet in/out counters, clear counter and a
// readback port) are built when DRAM_FIFO_CTRL_STATS_EN is defined.
// CLEAR_CYCLES must be at least 2.
module dram_fifo_ctrl #(
   parameter int SR_FIFO_CTRL  = 1,
   parameter int TIMEOUT       = 280,
   parameter int CLEAR_CYCLES  = 200,
   parameter int SETTLE_CYCLES = 200,
   parameter int CNT_W         = 16,
   parameter int HWM           = 64
) (
   input  logic             bus_clk,
   input  logic             bus_rst,
   input  logic             calib_complete,
   input  logic             soft_clear,
   dram_fifo_ctrl_if.master bus,
   output logic             fifo_ready,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic             almost_full
`ifdef DRAM_FIFO_CTRL_STATS_EN
   ,
   input  logic [1:0]       stats_sel,
   output logic [31:0]      stats_rb
`endif
);

   localparam int CYC_MAX = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);

   // The CLR_ON cycle plus the hold cycles span CLEAR_CYCLES, so the two
   // control writes land exactly CLEAR_CYCLES apart.
   localparam logic [CYC_W-1:0] HOLD_LAST   = CYC_W'(CLEAR_CYCLES - 2);
   localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
   localparam logic [7:0]       CTRL_ADDR   = 8'(SR_FIFO_CTRL);
   localparam logic [11:0]      TIMEOUT_F   = 12'(TIMEOUT);
   localparam logic [CNT_W-1:0] HWM_C       = CNT_W'(HWM);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {
      ST_WAIT_CALIB,
      ST_CLR_ON,
      ST_CLR_HOLD,
      ST_CLR_OFF,
      ST_SETTLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   function automatic logic [31:0] ctrl_word(input logic clr);
      return {16'h0, TIMEOUT_F, 2'b00, 1'b0, clr};
   endfunction

   logic [1:0]       calib_sync_q;
   logic             calib_s;
   state_t           state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             lost_q, lost_d;
   logic             in_pkt_q, in_pkt_d;
   logic             set_stb_q, set_stb_d;
   logic [7:0]       set_addr_q, set_addr_d;
   logic [31:0]      set_data_q, set_data_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic             almost_full_q;
   logic             pass_en;
   logic             in_acc;
   logic             inc;
   logic             dec;

   // two-flop synchronizer for the calibration flag
   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         calib_sync_q <= 2'b00;
      end else begin
         calib_sync_q <= {calib_sync_q[0], calib_complete};
      end
   end

   assign calib_s = calib_sync_q[1];

   // state, counters and settings-bus registers
   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         state_q    <= ST_WAIT_CALIB;
         cyc_q      <= '0;
         lost_q     <= 1'b0;
         set_stb_q  <= 1'b0;
         set_addr_q <= '0;
         set_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         lost_q     <= lost_d;
         set_stb_q  <= set_stb_d;
         set_addr_q <= set_addr_d;
         set_data_q <= set_data_d;
      end
   end

   // next state, wait counter and settings writes
   always_comb begin
      state_d    = state_q;
      cyc_d      = '0;
      lost_d     = lost_q;
      set_stb_d  = 1'b0;
      set_addr_d = set_addr_q;
      set_data_d = set_data_q;
      case (state_q)
         ST_WAIT_CALIB: begin
            if (calib_s) begin
               state_d = ST_CLR_ON;
            end
         end
         ST_CLR_ON: begin
            set_stb_d  = 1'b1;
            set_addr_d = CTRL_ADDR;
            set_data_d = ctrl_word(1'b1);
            state_d    = ST_CLR_HOLD;
         end
         ST_CLR_HOLD: begin
            cyc_d = cyc_q + 1'b1;
            if (cyc_q == HOLD_LAST) begin
               cyc_d   = '0;
               state_d = ST_CLR_OFF;
            end
         end
         ST_CLR_OFF: begin
            set_stb_d  = 1'b1;
            set_addr_d = CTRL_ADDR;
            set_data_d = ctrl_word(1'b0);
            state_d    = ST_SETTLE;
         end
         ST_SETTLE: begin
            cyc_d = cyc_q + 1'b1;
            if (cyc_q == SETTLE_LAST) begin
               cyc_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // losing calibration wins over a soft clear: the FIFO must not
            // be re-cleared until the DRAM is back
            if (!calib_s) begin
               lost_d  = 1'b1;
               state_d = ST_DRAIN;
            end else if (soft_clear) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!in_pkt_q) begin
               lost_d  = 1'b0;
               state_d = (lost_q || !calib_s) ? ST_WAIT_CALIB : ST_CLR_ON;
            end else if (!calib_s) begin
               lost_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_WAIT_CALIB;
         end
      endcase
   end

   // Pass-through is open in RUN, and stays open while a packet is in
   // flight so a started packet is always delivered whole.
   assign pass_en      = (state_q == ST_RUN) || in_pkt_q;
   assign bus.f_tdata  = bus.i_tdata;
   assign bus.f_tlast  = bus.i_tlast;
   assign bus.f_tvalid = bus.i_tvalid & pass_en;
   assign bus.i_tready = bus.f_tready & pass_en;

   assign in_acc = bus.i_tvalid & bus.i_tready;

   // packet-boundary tracker on the upstream side
   always_comb begin
      in_pkt_d = in_pkt_q;
      if (in_acc) begin
         in_pkt_d = ~bus.i_tlast;
      end
   end

   assign inc = bus.f_tvalid & bus.f_tready & bus.f_tlast;
   assign dec = bus.o_tvalid & bus.o_tready & bus.o_tlast;

   // saturating packet occupancy, forced to zero while the FIFO is cleared
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (state_q == ST_CLR_HOLD) begin
         pkt_cnt_d = '0;
      end else if (inc && !dec && (pkt_cnt_q != CNT_MAX)) begin
         pkt_cnt_d = pkt_cnt_q + 1'b1;
      end else if (dec && !inc && (pkt_cnt_q != '0)) begin
         pkt_cnt_d = pkt_cnt_q - 1'b1;
      end
   end

   // occupancy, packet tracker and high-watermark flag
   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         in_pkt_q      <= 1'b0;
         pkt_cnt_q     <= '0;
         almost_full_q <= 1'b0;
      end else begin
         in_pkt_q      <= in_pkt_d;
         pkt_cnt_q     <= pkt_cnt_d;
         almost_full_q <= (pkt_cnt_q >= HWM_C);
      end
   end

   assign bus.set_stb  = set_stb_q;
   assign bus.set_addr = set_addr_q;
   assign bus.set_data = set_data_q;
   assign fifo_ready   = (state_q == ST_RUN);
   assign busy         = (state_q != ST_RUN);
   assign pkt_cnt      = pkt_cnt_q;
   assign almost_full  = almost_full_q;

`ifdef DRAM_FIFO_CTRL_STATS_EN
   logic [31:0] pkts_in_q;
   logic [31:0] pkts_out_q;
   logic [15:0] clear_count_q;

   // free-running statistics; only bus_rst clears them
   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         pkts_in_q     <= '0;
         pkts_out_q    <= '0;
         clear_count_q <= '0;
      end else begin
         if (inc) begin
            pkts_in_q <= pkts_in_q + 1'b1;
         end
         if (dec) begin
            pkts_out_q <= pkts_out_q + 1'b1;
         end
         // CLR_ON lasts exactly one cycle, so this counts entries
         if (state_q == ST_CLR_ON) begin
            clear_count_q <= clear_count_q + 1'b1;
         end
      end
   end

   // readback mux: 0 packets in, 1 packets out, 2 clear count
   always_comb begin
      stats_rb = '0;
      case (stats_sel)
         2'd0:    stats_rb = pkts_in_q;
         2'd1:    stats_rb = pkts_out_q;
         2'd2:    stats_rb = {16'h0, clear_count_q};
         default: stats_rb = '0;
      endcase
   end
`endif

endmodule

// File: doc/dram_fifo_ctrl.md
Name: dram_fifo_ctrl

Overview:
- Bring-up and flow controller placed in front of axis_dram_fifo_single, all on bus_clk.
- Waits for DRAM calibration, then sequences a FIFO clear over the settings bus and programs the timeout field.
- Gates the upstream CHDR input so it is connected only while the FIFO is usable, and only at packet boundaries.
- Tracks packet occupancy in/out and raises a high-watermark flag; supports a host-requested soft clear.

Parameters:
- SR_FIFO_CTRL, 1: settings register address of the FIFO control word.
- TIMEOUT, 280: 12-bit timeout written into control word bits [15:4].
- CLEAR_CYCLES, 200: cycles clear bit held high.
- SETTLE_CYCLES, 200: cycles waited after clear deasserts before RUN.
- CNT_W, 16: packet occupancy counter width.
- HWM, 64: packet count at or above which almost_full asserts.

Ports:
- bus_clk  in  1  clock
- bus_rst  in  1  synchronous active-high reset
- calib_complete  in  1  DRAM calibration done; asynchronous to bus_clk
- soft_clear  in  1  single-cycle pulse requesting a FIFO clear
- i_tdata  in  64  upstream CHDR data
- i_tlast  in  1  upstream CHDR last
- i_tvalid  in  1  upstream CHDR valid
- i_tready  out  1  upstream CHDR ready
- f_tdata  out  64  to FIFO input
- f_tlast  out  1  to FIFO input
- f_tvalid  out  1  to FIFO input
- f_tready  in  1  from FIFO input
- o_tlast  in  1  FIFO output tap (monitor only)
- o_tvalid  in  1  FIFO output tap (monitor only)
- o_tready  in  1  FIFO output tap (monitor only)
- set_stb  out  1  settings strobe
- set_addr  out  8  settings address
- set_data  out  32  settings data
- fifo_ready  out  1  high only in RUN
- busy  out  1  high in any state other than RUN
- pkt_cnt  out  CNT_W  packets resident in FIFO
- almost_full  out  1  pkt_cnt >= HWM

Behaviour:
- calib_complete passes through a 2-flop synchronizer; calib_s is the synchronized value. All internal logic uses calib_s.
- Control word format: {16'h0, TIMEOUT[11:0], 2'b00, 1'b0, clr}.
- Reset values: state = WAIT_CALIB; set_stb = 0; set_addr = 0; set_data = 0; pkt_cnt = 0; fifo_ready = 0; busy = 1; almost_full = 0; in_pkt = 0.
- Settings writes: set_stb is a one-cycle pulse, registered. set_addr and set_data hold their values until the next write.
- FSM states and transitions:
  - WAIT_CALIB -> CLR_ON when calib_s = 1.
  - CLR_ON: write clr = 1; next cycle -> CLR_HOLD.
  - CLR_HOLD: count CLEAR_CYCLES; pkt_cnt forced to 0; -> CLR_OFF.
  - CLR_OFF: write clr = 0; -> SETTLE.
  - SETTLE: count SETTLE_CYCLES; -> RUN.
  - RUN: fifo_ready = 1.
    - soft_clear -> DRAIN.
    - calib_s = 0 -> DRAIN with a sticky flag set so that DRAIN exits to WAIT_CALIB instead of CLR_ON.
  - DRAIN: accept no new packet; wait for in_pkt = 0; -> CLR_ON, or -> WAIT_CALIB if the flag is set.
- Gating:
  - in_pkt sets on an accepted beat with tlast = 0 and clears on an accepted beat with tlast = 1.
  - Pass-through enabled when (state == RUN) or in_pkt = 1.
  - When enabled: f_* = i_*, i_tready = f_tready. Otherwise f_tvalid = 0 and i_tready = 0.
  - Gating never truncates a packet.
- Occupancy:
  - inc on f_tvalid & f_tready & f_tlast; dec on o_tvalid & o_tready & o_tlast.
  - Simultaneous inc and dec: no change.
  - Saturates at 2^CNT_W-1 and at 0; never wraps.
  - Cleared in CLR_HOLD.
  - almost_full is registered, one cycle after pkt_cnt.
- soft_clear outside RUN: ignored.
- Reset mid-operation: returns to WAIT_CALIB; no settings write issued during reset.
- A packet in flight is dropped upstream only by the upstream source's own reset.

Optional Feature:
- Macro: DRAM_FIFO_CTRL_STATS_EN.
- Defined:
  - Adds 32-bit wrapping counters pkts_in and pkts_out, cleared only by bus_rst.
  - Adds 16-bit clear_count, incremented on each CLR_ON entry.
  - Adds output stats_rb (32 bits): pkts_in when stats_sel = 0, pkts_out when stats_sel = 1.
  - Adds input stats_sel.
- Undefined: none of these ports or registers exist.

Test Plan:
- Reset, calib_complete rising at 5 us: exactly two writes to addr 1, data 0x00001181 then 0x00001180, 200 cycles apart. fifo_ready rises 200 cycles after the second write. i_tready = 0 throughout.
- RUN, push 10 packets of 20 beats with o_tready = 0: pkt_cnt = 10. With HWM = 8, almost_full = 1 after the 8th tlast. Drain all: pkt_cnt = 0, almost_full = 0.
- soft_clear pulsed at beat 5 of a 1024-beat packet: all 1024 beats reach f_*, then i_tready = 0. Clear write pair issued; fifo_ready returns after 400+ cycles; pkt_cnt = 0.
- Input tlast and output tlast handshakes in the same cycle: pkt_cnt unchanged.
- calib_complete dropped in RUN mid-packet: packet completes, block sits in WAIT_CALIB with no settings write. On calib return: clear pair issued, then RUN.
- bus_rst asserted in CLR_HOLD: set_stb = 0 on the next cycle, state = WAIT_CALIB, and the full clear sequence repeats after release.
